// File: rtl/hyperbus_cfg_seq.sv
// Boot-time HyperBus config-register sequencer: writes a fixed table with AXI isolated, then passes
// the SoC reg bus through. Optional per-entry readback/compare is enabled by HYPER_CFG_READBACK_EN.
package hyperbus_cfg_seq_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

module hyperbus_cfg_seq #(
  parameter int unsigned NumEntries    = 4,
  parameter int unsigned RegAddrWidth  = 32,
  parameter int unsigned RegDataWidth  = 32,
  parameter type         reg_req_t     = hyperbus_cfg_seq_pkg::reg_req_t,
  parameter type         reg_rsp_t     = hyperbus_cfg_seq_pkg::reg_rsp_t,
  parameter logic [NumEntries-1:0][RegAddrWidth-1:0] CfgAddr = '0,
  parameter logic [NumEntries-1:0][RegDataWidth-1:0] CfgData = '0,
  parameter int unsigned StartDelay    = 16,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        restart_i,
  input  reg_req_t                    cfg_req_i,
  output reg_rsp_t                    cfg_rsp_o,
  output reg_req_t                    reg_req_o,
  input  reg_rsp_t                    reg_rsp_i,
  output logic                        axi_isolate_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic [$clog2(NumEntries):0] err_idx_o
);

  localparam int unsigned ErrIdxW = $clog2(NumEntries) + 1;
  localparam int unsigned EntW    = (NumEntries > 1) ? $clog2(NumEntries) : 1;
  localparam int unsigned DlyW    = (StartDelay > 1) ? $clog2(StartDelay) : 1;
  localparam int unsigned TmoW    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  localparam logic [EntW-1:0] LastIdx = EntW'(NumEntries - 1);
  localparam logic [DlyW-1:0] DlyLast = DlyW'((StartDelay > 0) ? StartDelay - 1 : 0);
  localparam logic [TmoW-1:0] TmoLast = TmoW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

`ifdef HYPER_CFG_READBACK_EN
  typedef enum logic [2:0] {
    S_WAIT, S_WR, S_RD, S_CHK, S_NEXT, S_DONE, S_ERROR
  } state_e;
`else
  typedef enum logic [2:0] {
    S_WAIT, S_WR, S_NEXT, S_DONE, S_ERROR
  } state_e;
`endif

  state_e               state_q, state_d;
  logic [EntW-1:0]      idx_q, idx_d;
  logic [DlyW-1:0]      dly_q, dly_d;
  logic [TmoW-1:0]      tmo_q, tmo_d;
  logic [ErrIdxW-1:0]   err_idx_q, err_idx_d;
  logic                 pend_q, pend_d;
`ifdef HYPER_CFG_READBACK_EN
  logic [RegDataWidth-1:0] rdata_q, rdata_d;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_WAIT;
      idx_q     <= '0;
      dly_q     <= '0;
      tmo_q     <= '0;
      err_idx_q <= '0;
      pend_q    <= 1'b0;
`ifdef HYPER_CFG_READBACK_EN
      rdata_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dly_q     <= dly_d;
      tmo_q     <= tmo_d;
      err_idx_q <= err_idx_d;
      pend_q    <= pend_d;
`ifdef HYPER_CFG_READBACK_EN
      rdata_q   <= rdata_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dly_d     = dly_q;
    tmo_d     = '0;
    err_idx_d = err_idx_q;
    pend_d    = 1'b0;
`ifdef HYPER_CFG_READBACK_EN
    rdata_d   = rdata_q;
`endif
    reg_req_o = '0;
    cfg_rsp_o = '0;

    case (state_q)
      S_WAIT: begin
        if (StartDelay == 0 || dly_q == DlyLast) begin
          state_d = S_WR;
          idx_d   = '0;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end

      S_WR: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.write = 1'b1;
        reg_req_o.addr  = CfgAddr[idx_q];
        reg_req_o.wdata = CfgData[idx_q];
        reg_req_o.wstrb = '1;
        if (reg_rsp_i.ready) begin
          if (reg_rsp_i.error) begin
            state_d   = S_ERROR;
            err_idx_d = ErrIdxW'(idx_q);
          end else begin
`ifdef HYPER_CFG_READBACK_EN
            state_d = S_RD;
`else
            state_d = S_NEXT;
`endif
          end
        end else if (tmo_q == TmoLast) begin
          state_d   = S_ERROR;
          err_idx_d = ErrIdxW'(idx_q);
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

`ifdef HYPER_CFG_READBACK_EN
      S_RD: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.write = 1'b0;
        reg_req_o.addr  = CfgAddr[idx_q];
        if (reg_rsp_i.ready) begin
          if (reg_rsp_i.error) begin
            state_d   = S_ERROR;
            err_idx_d = ErrIdxW'(idx_q);
          end else begin
            state_d = S_CHK;
            rdata_d = reg_rsp_i.rdata;
          end
        end else if (tmo_q == TmoLast) begin
          state_d   = S_ERROR;
          err_idx_d = ErrIdxW'(idx_q);
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_CHK: begin
        if (rdata_q != CfgData[idx_q]) begin
          state_d   = S_ERROR;
          err_idx_d = ErrIdxW'(idx_q);
        end else begin
          state_d = S_NEXT;
        end
      end
`endif

      S_NEXT: begin
        if (idx_q == LastIdx) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_WR;
        end
      end

      S_DONE, S_ERROR: begin
        reg_req_o = cfg_req_i;
        cfg_rsp_o = reg_rsp_i;
        // A restart must not cut an upstream transaction in half; hold it until valid is low.
        pend_d    = pend_q | restart_i;
        if (pend_d && !cfg_req_i.valid) begin
          pend_d    = 1'b0;
          state_d   = S_WR;
          idx_d     = '0;
          err_idx_d = '0;
        end
      end

      default: begin
        state_d = S_ERROR;
      end
    endcase
  end

  assign axi_isolate_o = (state_q != S_DONE);
  assign busy_o        = (state_q != S_DONE) && (state_q != S_ERROR);
  assign done_o        = (state_q == S_DONE);
  assign err_o         = (state_q == S_ERROR);
  assign err_idx_o     = err_idx_q;

`ifndef SYNTHESIS
  logic fsm_access;
`ifdef HYPER_CFG_READBACK_EN
  assign fsm_access = (state_q == S_WR) || (state_q == S_RD);
`else
  assign fsm_access = (state_q == S_WR);
`endif

  a_hold_payload: assert property (@(posedge clk_i) disable iff (rst_i)
    (fsm_access && !reg_rsp_i.ready && tmo_q != TmoLast) |=> (reg_req_o.valid && $stable(reg_req_o)));

  a_upstream_stalled: assert property (@(posedge clk_i) disable iff (rst_i)
    busy_o |-> (cfg_rsp_o == '0));
`endif

endmodule

// File: tb/tb_hyperbus_cfg_seq.sv
// Bench for hyperbus_cfg_seq: a small wrapper model answers the reg port, a scoreboard checks each
// accepted reg-port transaction in order, and directed sequences check status/passthrough behaviour.
`timescale 1ns/1ps
module tb_hyperbus_cfg_seq;
  import hyperbus_cfg_seq_pkg::*;

  localparam int N = 4;
  localparam logic [N-1:0][31:0] CFG_A = {32'h0000_001C, 32'h0000_0018, 32'h0000_0004, 32'h0000_0000};
  localparam logic [N-1:0][31:0] CFG_D = {32'h0000_0101, 32'h8000_0004, 32'h0000_0003, 32'h0012_3456};
`ifdef HYPER_CFG_READBACK_EN
  localparam int DONE_CYC = 40;
`else
  localparam int DONE_CYC = 28;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       restart_i = 1'b0;
  reg_req_t   cfg_req_i;
  reg_rsp_t   cfg_rsp_o;
  reg_req_t   reg_req_o;
  reg_rsp_t   reg_rsp_i;
  logic       axi_isolate_o, busy_o, done_o, err_o;
  logic [2:0] err_idx_o;

  always #5 clk_i = ~clk_i;

  hyperbus_cfg_seq #(
    .NumEntries(N), .StartDelay(16), .TimeoutCycles(8), .CfgAddr(CFG_A), .CfgData(CFG_D)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .restart_i(restart_i),
    .cfg_req_i(cfg_req_i), .cfg_rsp_o(cfg_rsp_o),
    .reg_req_o(reg_req_o), .reg_rsp_i(reg_rsp_i),
    .axi_isolate_o(axi_isolate_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .err_idx_o(err_idx_o)
  );

  // Wrapper model: ready in the second cycle of valid; per-address stall, error and corrupt-read knobs.
  logic        prev_vld;
  logic [31:0] mem [8];
  logic        hold_en = 1'b0, err_en = 1'b0, bad_en = 1'b0;
  logic [31:0] hold_addr = '0, err_addr = '0, bad_addr = '0;
  logic        rdy;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_vld <= 1'b0;
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else begin
      prev_vld <= reg_req_o.valid && !reg_rsp_i.ready;
      if (reg_req_o.valid && reg_rsp_i.ready && reg_req_o.write)
        mem[reg_req_o.addr[4:2]] <= reg_req_o.wdata;
    end
  end

  always_comb begin
    reg_rsp_i = '0;
    rdy = reg_req_o.valid && prev_vld && !(hold_en && reg_req_o.addr == hold_addr);
    reg_rsp_i.ready = rdy;
    reg_rsp_i.error = rdy && err_en && (reg_req_o.addr == err_addr);
    if (rdy && !reg_req_o.write)
      reg_rsp_i.rdata = (bad_en && reg_req_o.addr == bad_addr) ? 32'hDEAD_BEEF : mem[reg_req_o.addr[4:2]];
  end

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } xact_t;

  xact_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;

  always @(negedge clk_i) begin
    xact_t got, e;
    if (!rst_i && reg_req_o.valid && reg_rsp_i.ready) begin
      got = {reg_req_o.write, reg_req_o.addr, reg_req_o.wdata, reg_req_o.wstrb};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL xact_unexpected: got w=%b addr=%h wdata=%h, required no transaction", got.write, got.addr, got.wdata);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL xact: got w=%b addr=%h wdata=%h strb=%h, required w=%b addr=%h wdata=%h strb=%h",
                   got.write, got.addr, got.wdata, got.wstrb, e.write, e.addr, e.wdata, e.wstrb);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic push_wr(input int i);
    exp_q.push_back({1'b1, CFG_A[i], CFG_D[i], 4'hF});
  endtask

  task automatic push_rd(input int i);
    exp_q.push_back({1'b0, CFG_A[i], 32'h0, 4'h0});
  endtask

  task automatic push_entry(input int i);
    push_wr(i);
`ifdef HYPER_CFG_READBACK_EN
    push_rd(i);
`endif
  endtask

  task automatic pulse_restart();
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
  endtask

  task automatic wait_err(input string name);
    int n = 0;
    while (!err_o && n < 200) begin tick(); n++; end
    check(name, err_o, 1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done_o && n < 200) begin tick(); n++; end
    check(name, done_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1);
  end

  initial begin
    int n;
    cfg_req_i = '0;
    repeat (3) tick();
    check("rst_isolate", axi_isolate_o, 1);
    check("rst_busy", busy_o, 1);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_err_idx", err_idx_o, 0);
    check("rst_req_valid", reg_req_o.valid, 0);
    check("rst_cfg_rsp", cfg_rsp_o, 0);

    // Boot sequence with an upstream read held pending throughout; restart during WAIT is ignored.
    for (int i = 0; i < N; i++) push_entry(i);
    exp_q.push_back({1'b0, CFG_A[2], 32'h0, 4'h0});
    cfg_req_i.valid = 1'b1;
    cfg_req_i.addr  = CFG_A[2];
    rst_i = 1'b0;
    cyc = 0;
    restart_i = 1'b1;
    n = 0;
    do begin
      tick();
      restart_i = 1'b0;
      n++;
    end while (!reg_req_o.valid && n < 100);
    check("first_valid_cycle", n, 16);
    while (!done_o && cyc < 200) begin
      check("cfg_stall_ready", cfg_rsp_o.ready, 0);
      tick();
    end
    check("done_set", done_o, 1);
    check("done_cycle", cyc, DONE_CYC);
    check("done_isolate", axi_isolate_o, 0);
    check("done_busy", busy_o, 0);
    check("done_err", err_o, 0);

    n = 0;
    while (!cfg_rsp_o.ready && n < 20) begin tick(); n++; end
    check("pt_ready", cfg_rsp_o.ready, 1);
    check("pt_same_cycle", cfg_rsp_o.ready, reg_rsp_i.ready);
    check("pt_rdata", cfg_rsp_o.rdata, CFG_D[2]);
    check("pt_addr", reg_req_o.addr, CFG_A[2]);
    tick();
    cfg_req_i = '0;
    tick();

    // Restart while an upstream request is stalled: deferred until valid drops.
    hold_en = 1'b1;
    hold_addr = 32'h0000_0200;
    cfg_req_i.valid = 1'b1;
    cfg_req_i.addr  = 32'h0000_0200;
    pulse_restart();
    for (int i = 0; i < 3; i++) begin
      check("defer_done", done_o, 1);
      check("defer_isolate", axi_isolate_o, 0);
      tick();
    end
    for (int i = 0; i < N; i++) push_entry(i);
    cfg_req_i = '0;
    tick();
    check("rerun_valid", reg_req_o.valid, 1);
    check("rerun_addr", reg_req_o.addr, CFG_A[0]);
    check("rerun_isolate", axi_isolate_o, 1);
    check("rerun_done", done_o, 0);
    hold_en = 1'b0;
    wait_done("rerun_done_set");

    // Error response on entry 0: nothing after it may be issued.
    err_en = 1'b1;
    err_addr = CFG_A[0];
    push_wr(0);
    pulse_restart();
    wait_err("rsp_err_set");
    check("rsp_err_idx", err_idx_o, 0);
    check("rsp_err_isolate", axi_isolate_o, 1);
    check("rsp_err_busy", busy_o, 0);
    check("rsp_err_done", done_o, 0);
    repeat (10) tick();
    check("rsp_err_no_more", exp_q.size(), 0);
    err_en = 1'b0;

    // Ready withheld on entry 2: valid stays up for exactly TimeoutCycles cycles.
    hold_en = 1'b1;
    hold_addr = CFG_A[2];
    push_entry(0);
    push_entry(1);
    pulse_restart();
    n = 0;
    while (!(reg_req_o.valid && reg_req_o.addr == CFG_A[2]) && n < 100) begin tick(); n++; end
    check("tmo_entry2_seen", reg_req_o.addr, CFG_A[2]);
    n = 0;
    while (reg_req_o.valid && n < 50) begin tick(); n++; end
    check("tmo_stall_cycles", n, 8);
    check("tmo_err", err_o, 1);
    check("tmo_err_idx", err_idx_o, 2);
    check("tmo_isolate", axi_isolate_o, 1);
    hold_en = 1'b0;

`ifdef HYPER_CFG_READBACK_EN
    // Entry 1 reads back a wrong value.
    bad_en = 1'b1;
    bad_addr = CFG_A[1];
    push_entry(0);
    push_wr(1);
    push_rd(1);
    pulse_restart();
    wait_err("rb_err_set");
    check("rb_err_idx", err_idx_o, 1);
    bad_en = 1'b0;
`endif

    // Async reset in the middle of an access drops valid without a clock edge.
    pulse_restart();
    check("arst_pre_valid", reg_req_o.valid, 1);
    rst_i = 1'b1;
    #1;
    check("arst_valid", reg_req_o.valid, 0);
    check("arst_isolate", axi_isolate_o, 1);
    check("arst_busy", busy_o, 1);
    check("arst_err", err_o, 0);
    repeat (2) tick();
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
